fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: the NOP filler word,
// FSM state encodings, the PC increment and word alignment.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_INC           = 32'd4;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_KILL  = 2'd2;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, a registered IF/ID
// slot, and redirect handling that squashes an in-flight response via KILL.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic        imem_rsp_ready_o,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  input  logic        ready_i
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q;
  logic        slot_free;
  logic        req_hs;
  logic        rsp_hs;
  logic        rsp_load;

  // The IF/ID slot can take a new instruction if empty or drained this cycle.
  assign slot_free = !valid_o || ready_i;

  // Gated by rst_i so the request drops the instant reset asserts.
  assign imem_req_o  = !rst_i && (state_q == ST_FETCH) && !redirect_i && slot_free;
  assign imem_addr_o = pc_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    imem_rsp_ready_o = 1'b0;
    case (state_q)
      ST_WAIT: imem_rsp_ready_o = slot_free;
      ST_KILL: imem_rsp_ready_o = 1'b1;
      default: imem_rsp_ready_o = 1'b0;
    endcase
  end

  assign req_hs   = imem_req_o && imem_req_ready_i;
  assign rsp_hs   = imem_rsp_valid_i && imem_rsp_ready_o;
  assign rsp_load = (state_q == ST_WAIT) && rsp_hs && !redirect_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (req_hs) state_d = ST_WAIT;
      ST_WAIT: begin
        if (rsp_hs)          state_d = ST_FETCH;
        else if (redirect_i) state_d = ST_KILL;
      end
      ST_KILL:  if (rsp_hs) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an async reset branch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      valid_o <= 1'b0;
      inst_o  <= NOP_INST;
      pc_o    <= RESET_PC;
      fault_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        pc_q    <= align_word(redirect_pc_i);
        valid_o <= 1'b0;
        inst_o  <= NOP_INST;
        fault_o <= 1'b0;
      end else if (rsp_load) begin
        pc_q    <= pc_q + PC_INC;
        valid_o <= 1'b1;
        inst_o  <= imem_rsp_err_i ? NOP_INST : imem_rsp_data_i;
        pc_o    <= pc_q;
        fault_o <= imem_rsp_err_i;
      end else if (ready_i) begin
        valid_o <= 1'b0;
        inst_o  <= NOP_INST;
        fault_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a zero-wait memory model with a response hold
// and an error address, stepped through reset, stall, fault, redirect and wrap.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        imem_rsp_ready_o;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic        ready_i;

  int n_cmp = 0;
  int n_err = 0;

  // memory model state
  logic        pend;
  logic [31:0] pend_addr;
  logic        rsp_en;
  logic [31:0] err_addr;
  logic        err_en;

  fetch_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .imem_rsp_ready_o (imem_rsp_ready_o),
    .valid_o          (valid_o),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .fault_o          (fault_o),
    .ready_i          (ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    return 32'hA000_0000 | addr;
  endfunction

  assign imem_req_ready_i = 1'b1;
  assign imem_rsp_valid_i = pend && rsp_en;
  assign imem_rsp_data_i  = mem_word(pend_addr);
  assign imem_rsp_err_i   = err_en && (pend_addr == err_addr);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend      <= 1'b0;
      pend_addr <= 32'h0;
    end else begin
      if (imem_rsp_valid_i && imem_rsp_ready_o) pend <= 1'b0;
      if (imem_req_o && imem_req_ready_i) begin
        pend      <= 1'b1;
        pend_addr <= imem_addr_o;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic f);
    check({tag, ".valid"}, 32'(valid_o), 32'(v));
    check({tag, ".inst"},  inst_o, inst);
    check({tag, ".pc"},    pc_o, pc);
    check({tag, ".fault"}, 32'(fault_o), 32'(f));
  endtask

  initial begin
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    ready_i       = 1'b1;
    rsp_en        = 1'b1;
    err_en        = 1'b0;
    err_addr      = 32'h8;

    // reset values while rst_i is held
    step();
    step();
    check_ifid("rst", 1'b0, 32'h13, 32'h0, 1'b0);
    check("rst.req",      32'(imem_req_o), 32'h0);
    check("rst.rsp_rdy",  32'(imem_rsp_ready_o), 32'h0);
    check("rst.addr",     imem_addr_o, 32'h0);

    rst_i = 1'b0;
    #1;
    check("c0.req",  32'(imem_req_o), 32'h1);
    check("c0.addr", imem_addr_o, 32'h0);
    step();  // request accepted -> WAIT
    check("c1.req",     32'(imem_req_o), 32'h0);
    check("c1.rsp_rdy", 32'(imem_rsp_ready_o), 32'h1);
    check("c1.valid",   32'(valid_o), 32'h0);
    step();  // first instruction lands two cycles after release
    check_ifid("c2", 1'b1, 32'h0050_0093, 32'h0, 1'b0);
    check("c2.addr", imem_addr_o, 32'h4);
    check("c2.req",  32'(imem_req_o), 32'h1);

    // decode stall holds IF/ID and blocks requests
    ready_i = 1'b0;
    #1;
    check("stall.req", 32'(imem_req_o), 32'h0);
    step();
    check_ifid("stall", 1'b1, 32'h0050_0093, 32'h0, 1'b0);
    check("stall.req2", 32'(imem_req_o), 32'h0);
    ready_i = 1'b1;
    #1;
    check("resume.req",  32'(imem_req_o), 32'h1);
    check("resume.addr", imem_addr_o, 32'h4);
    step();
    check_ifid("drain", 1'b0, 32'h13, 32'h0, 1'b0);
    step();
    check_ifid("pc4", 1'b1, 32'hA000_0004, 32'h4, 1'b0);
    check("pc4.addr", imem_addr_o, 32'h8);

    // faulted fetch at pc 8
    err_en = 1'b1;
    step();
    step();
    check_ifid("fault", 1'b1, 32'h13, 32'h8, 1'b1);
    check("fault.addr", imem_addr_o, 32'hC);
    err_en = 1'b0;

    // redirect while the response for pc 12 is held back
    rsp_en = 1'b0;
    step();  // request for 12 accepted
    check("wait.rsp_rdy", 32'(imem_rsp_ready_o), 32'h1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    #1;
    check("redir.req", 32'(imem_req_o), 32'h0);
    step();  // WAIT -> KILL
    redirect_i = 1'b0;
    #1;
    check_ifid("kill", 1'b0, 32'h13, 32'h8, 1'b0);
    check("kill.addr",    imem_addr_o, 32'h100);
    check("kill.req",     32'(imem_req_o), 32'h0);
    check("kill.rsp_rdy", 32'(imem_rsp_ready_o), 32'h1);
    rsp_en = 1'b1;
    step();  // stale response discarded -> FETCH
    check_ifid("discard", 1'b0, 32'h13, 32'h8, 1'b0);
    check("discard.req",  32'(imem_req_o), 32'h1);
    check("discard.addr", imem_addr_o, 32'h100);
    step();
    step();
    check_ifid("tgt", 1'b1, 32'hA000_0100, 32'h100, 1'b0);

    // redirect to the top word (unaligned target) and wrap
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    step();
    redirect_i = 1'b0;
    #1;
    check("top.addr",  imem_addr_o, 32'hFFFF_FFFC);
    check("top.valid", 32'(valid_o), 32'h0);
    step();
    step();
    check_ifid("top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    check("wrap.addr", imem_addr_o, 32'h0);

    // asynchronous reset in the middle of WAIT
    step();  // request for 0 accepted -> WAIT
    check("prerst.rsp_rdy", 32'(imem_rsp_ready_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check_ifid("arst", 1'b0, 32'h13, 32'h0, 1'b0);
    check("arst.req",     32'(imem_req_o), 32'h0);
    check("arst.rsp_rdy", 32'(imem_rsp_ready_o), 32'h0);
    check("arst.addr",    imem_addr_o, 32'h0);
    step();
    rst_i = 1'b0;
    step();
    step();
    check_ifid("rerun", 1'b1, 32'h0050_0093, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
